// File: rtl/paicore_link_echo.sv
`default_nettype none
// ============================================================================
// Module   : paicore_link_echo
// Brief    : Per-channel 4-phase link responder -> FIFO -> link initiator echo,
//            standing in for the PAICORE chip on the parallel link interface.
// Revision : 1.0
// ============================================================================
module paicore_link_echo #(
    parameter int Channel    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  i_enable,
    input  logic [Channel-1:0]    in_request,
    input  logic [Channel*32-1:0] in_din,
    output logic [Channel-1:0]    in_acknowledge,
    output logic [Channel-1:0]    out_request,
    output logic [Channel*32-1:0] out_dout,
    input  logic [Channel-1:0]    out_acknowledge,
    output logic [31:0]           o_frame_cnt,
    output logic                  o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_WAIT = 2'd2
    } t_state_t;

    logic [Channel-1:0] w_push;
    logic [Channel-1:0] w_busy_nxt;
    logic [31:0]        w_npush;
    logic [31:0]        r_frame_cnt;
    logic               r_busy;

    for (genvar c = 0; c < Channel; c++) begin : g_ch
        r_state_t      r_rstate, w_rstate_nxt;
        t_state_t      r_tstate, w_tstate_nxt;
        logic [31:0]   r_mem [FIFO_DEPTH];
        logic [AW-1:0] r_wptr, r_rptr;
        logic [CW-1:0] r_count, w_count_nxt;
        logic          w_full, w_empty, w_push_ch, w_pop;
        logic          r_ack, r_req;
        logic [31:0]   r_dout;

        assign w_full  = (r_count == C_FULL);
        assign w_empty = (r_count == '0);

        always_comb begin
            w_rstate_nxt = r_rstate;
            w_push_ch    = 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (in_request[c] && i_enable && !w_full) begin
                        w_push_ch    = 1'b1;
                        w_rstate_nxt = R_ACK;
                    end
                end
                R_ACK: begin
                    if (!in_request[c]) begin
                        w_rstate_nxt = R_IDLE;
                    end
                end
                default: w_rstate_nxt = R_IDLE;
            endcase
        end

        always_comb begin
            w_tstate_nxt = r_tstate;
            w_pop        = 1'b0;
            case (r_tstate)
                T_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_tstate_nxt = T_REQ;
                    end
                end
                T_REQ: begin
                    if (out_acknowledge[c]) begin
                        w_tstate_nxt = T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (!out_acknowledge[c]) begin
                        w_tstate_nxt = T_IDLE;
                    end
                end
                default: w_tstate_nxt = T_IDLE;
            endcase
        end

        always_comb begin
            w_count_nxt = r_count;
            case ({w_push_ch, w_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_rstate <= R_IDLE;
                r_tstate <= T_IDLE;
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_count  <= '0;
                r_ack    <= 1'b0;
                r_req    <= 1'b0;
                r_dout   <= '0;
            end else begin
                r_rstate <= w_rstate_nxt;
                r_tstate <= w_tstate_nxt;
                r_count  <= w_count_nxt;
                r_ack    <= (w_rstate_nxt == R_ACK);
                r_req    <= (w_tstate_nxt == T_REQ);
                if (w_push_ch) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                    r_dout <= r_mem[r_rptr];
                end
            end
        end

        // Storage carries no reset; validity is tracked by the pointers/count.
        always_ff @(posedge aclk) begin
            if (w_push_ch) begin
                r_mem[r_wptr] <= in_din[32*c +: 32];
            end
        end

        assign w_push[c]              = w_push_ch;
        assign w_busy_nxt[c]          = (w_count_nxt != '0) || (w_rstate_nxt != R_IDLE) ||
                                        (w_tstate_nxt != T_IDLE);
        assign in_acknowledge[c]      = r_ack;
        assign out_request[c]         = r_req;
        assign out_dout[32*c +: 32]   = r_dout;
    end

    always_comb begin
        w_npush = '0;
        for (int i = 0; i < Channel; i++) begin
            w_npush = w_npush + 32'(w_push[i]);
        end
    end

    // Busy is registered from next-state values so it tracks the live state exactly.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_cnt <= r_frame_cnt + w_npush;
            r_busy      <= |w_busy_nxt;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_busy      = r_busy;

endmodule
`default_nettype wire
